// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared widths, opcodes, IR field positions and enums for the control-step sequencer.
package cpu_ctrl_pkg;
  localparam int DATA_W      = 32;
  localparam int NREG        = 16;
  localparam int OPC_W       = 5;
  localparam int REG_W       = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = $clog2(MEM_TIMEOUT);
  localparam int OPC_LSB     = 27;
  localparam int RA_LSB      = 23;
  localparam int RB_LSB      = 19;
  localparam int RC_LSB      = 15;
  localparam logic [OPC_W-1:0] OP_ALU3_LO = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ALU3_HI = 5'b01110;
  localparam logic [OPC_W-1:0] OP_MUL     = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV     = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG     = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT     = 5'b10010;
  localparam logic [OPC_W-1:0] OP_HALT    = 5'b11011;
  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_OPC  = 2'b01;
  localparam logic [1:0] FLT_MEM  = 2'b10;
  typedef enum logic [2:0] {ALU3, MULDIV, UNARY, HALT_OP, ILLEGAL} cls_t;
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
  function automatic logic [NREG-1:0] reg_sel(input logic [REG_W-1:0] r);
    return NREG'(1) << r;
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: maps an opcode onto its execute-sequence class.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output cls_t             cls
);
  always_comb
    cls = (opc >= OP_ALU3_LO && opc <= OP_ALU3_HI) ? ALU3 :
          (opc == OP_MUL || opc == OP_DIV)         ? MULDIV :
          (opc == OP_NEG || opc == OP_NOT)         ? UNARY :
          (opc == OP_HALT)                         ? HALT_OP : ILLEGAL;
endmodule

// File: rtl/control_step_sequencer.sv
// control_step_sequencer: fetch/decode/execute control-step FSM driving the CPU datapath enables.
module control_step_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              run,
  input  logic [DATA_W-1:0] ir,
  input  logic              mem_rdy,
  output logic [NREG-1:0]   gpr_out,
  output logic [NREG-1:0]   gpr_in,
  output logic              pc_out,
  output logic              zlow_out,
  output logic              zhigh_out,
  output logic              mdr_out,
  output logic              pc_in,
  output logic              ir_in,
  output logic              mar_in,
  output logic              mdr_in,
  output logic              y_in,
  output logic              z_in,
  output logic              hi_in,
  output logic              lo_in,
  output logic              inc_pc,
  output logic              read,
  output logic [OPC_W-1:0]  alu_op,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fault
);
  state_t state, next;
  cls_t cls;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0] fault_nxt;
  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] ra, rb, rc;
  logic is_a3, is_md, is_un;
  logic unused_ir;
  assign opc = ir[OPC_LSB +: OPC_W];
  assign ra = ir[RA_LSB +: REG_W];
  assign rb = ir[RB_LSB +: REG_W];
  assign rc = ir[RC_LSB +: REG_W];
  assign unused_ir = ^ir[RC_LSB-1:0];
  assign is_a3 = cls == ALU3;
  assign is_md = cls == MULDIV;
  assign is_un = cls == UNARY;
  ctrl_decode u_decode (.opc(opc), .cls(cls));
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= IDLE;
      cnt <= '0;
      fault <= FLT_NONE;
    end else begin
      state <= next;
      cnt <= cnt_nxt;
      fault <= fault_nxt;
    end
  always_comb begin
    next = state;
    fault_nxt = fault;
    case (state)
      IDLE: next = run ? T0 : IDLE;
      T0: next = T1;
      T1: if (mem_rdy) next = T2;
          else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            next = HALT;
            fault_nxt = FLT_MEM;
          end
      T2: next = T3;
      T3: begin
        next = (cls == HALT_OP || cls == ILLEGAL) ? HALT : T4;
        fault_nxt = (cls == ILLEGAL) ? FLT_OPC : fault;
      end
      T4: next = T5;
      T5: next = T6;
      default: next = state;
    endcase
    if (done) next = run ? T0 : IDLE;
    cnt_nxt = (state == T1 && next == T1) ? cnt + CNT_W'(1) : '0;
  end
  // Outputs decode the registered state (and the stable IR during execute), so each step holds for its whole cycle.
  always_comb begin
    gpr_out = '0;
    gpr_in = '0;
    pc_out = 1'b0;
    zlow_out = 1'b0;
    zhigh_out = 1'b0;
    mdr_out = 1'b0;
    pc_in = 1'b0;
    ir_in = 1'b0;
    mar_in = 1'b0;
    mdr_in = 1'b0;
    y_in = 1'b0;
    z_in = 1'b0;
    hi_in = 1'b0;
    lo_in = 1'b0;
    inc_pc = 1'b0;
    read = 1'b0;
    alu_op = '0;
    done = 1'b0;
    busy = state != IDLE && state != HALT;
    case (state)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in = 1'b1;
      end
      T1: begin
        zlow_out = 1'b1;
        pc_in = cnt == '0;
        read = 1'b1;
        mdr_in = 1'b1;
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in = 1'b1;
      end
      T3: begin
        gpr_out = (is_a3 || is_un) ? reg_sel(rb) : is_md ? reg_sel(ra) : '0;
        y_in = is_a3 || is_md;
        z_in = is_un;
        alu_op = is_un ? opc : '0;
      end
      T4: begin
        gpr_out = is_a3 ? reg_sel(rc) : is_md ? reg_sel(rb) : '0;
        alu_op = (is_a3 || is_md) ? opc : '0;
        z_in = is_a3 || is_md;
        zlow_out = is_un;
        gpr_in = is_un ? reg_sel(ra) : '0;
        done = is_un;
      end
      T5: begin
        zlow_out = 1'b1;
        gpr_in = is_a3 ? reg_sel(ra) : '0;
        lo_in = is_md;
        done = is_a3;
      end
      T6: begin
        zhigh_out = 1'b1;
        hi_in = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_step_sequencer.sv
// tb_control_step_sequencer: directed per-cycle expectations queued by stimulus, checked by a negedge monitor.
module tb_control_step_sequencer;
  typedef struct packed {
    logic [15:0] go, gi;
    logic pc_o, zl_o, zh_o, mdr_o, pc_i, ir_i, mar_i, mdr_i, y_i, z_i, hi_i, lo_i, inc, rd;
    logic [4:0] op;
    logic busy, done;
    logic [1:0] flt;
  } obs_t;
  logic clk = 1'b0, clr_n, run, mem_rdy;
  logic [31:0] ir;
  logic [15:0] gpr_out, gpr_in;
  logic pc_out, zlow_out, zhigh_out, mdr_out, pc_in, ir_in, mar_in, mdr_in;
  logic y_in, z_in, hi_in, lo_in, inc_pc, read, busy, done;
  logic [4:0] alu_op;
  logic [1:0] fault;
  obs_t act, e_pop;
  obs_t exp_q[$];
  string tag_q[$];
  string t_pop;
  int checks = 0, errors = 0;
  control_step_sequencer dut (
    .clk(clk), .clr_n(clr_n), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .gpr_out(gpr_out), .gpr_in(gpr_in), .pc_out(pc_out), .zlow_out(zlow_out),
    .zhigh_out(zhigh_out), .mdr_out(mdr_out), .pc_in(pc_in), .ir_in(ir_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in),
    .lo_in(lo_in), .inc_pc(inc_pc), .read(read), .alu_op(alu_op), .busy(busy),
    .done(done), .fault(fault)
  );
  always #5 clk = ~clk;
  assign act = {gpr_out, gpr_in, pc_out, zlow_out, zhigh_out, mdr_out, pc_in, ir_in, mar_in,
                mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read, alu_op, busy, done, fault};
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      e_pop = exp_q.pop_front();
      t_pop = tag_q.pop_front();
      checks++;
      if (act !== e_pop) begin
        errors++;
        $display("FAIL %s: got %h expected %h", t_pop, act, e_pop);
      end
    end
  // The bus mux is priority-encoded, so more than one source is a datapath hazard.
  always @(negedge clk) begin
    checks++;
    if ($countones({gpr_out, pc_out, zlow_out, zhigh_out, mdr_out}) > 1) begin
      errors++;
      $display("FAIL bus_onehot: got %h %b required at most one source", gpr_out, {pc_out, zlow_out, zhigh_out, mdr_out});
    end
  end
  function automatic obs_t f_idle(input logic [1:0] flt);
    obs_t o = '0;
    o.flt = flt;
    return o;
  endfunction
  function automatic obs_t f_busy();
    obs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction
  function automatic obs_t f_t0();
    obs_t o = f_busy();
    o.pc_o = 1'b1; o.mar_i = 1'b1; o.inc = 1'b1; o.z_i = 1'b1;
    return o;
  endfunction
  function automatic obs_t f_t1(input logic first);
    obs_t o = f_busy();
    o.zl_o = 1'b1; o.pc_i = first; o.rd = 1'b1; o.mdr_i = 1'b1;
    return o;
  endfunction
  function automatic obs_t f_t2();
    obs_t o = f_busy();
    o.mdr_o = 1'b1; o.ir_i = 1'b1;
    return o;
  endfunction
  function automatic obs_t ex(input logic [15:0] go, gi, input logic [4:0] op,
                              input logic zl, zh, y, z, lo, hi, dn);
    obs_t o = f_busy();
    o.go = go; o.gi = gi; o.op = op; o.zl_o = zl; o.zh_o = zh;
    o.y_i = y; o.z_i = z; o.lo_i = lo; o.hi_i = hi; o.done = dn;
    return o;
  endfunction
  task automatic step(input string tag, input obs_t e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask
  task automatic reset_dut(input string tag);
    @(posedge clk);
    #1 clr_n = 1'b0;
    #1;
    exp_q.push_back(f_idle(2'b00));
    tag_q.push_back(tag);
    @(posedge clk);
    #1 clr_n = 1'b1;
    exp_q.push_back(f_idle(2'b00));
    tag_q.push_back({tag, "_idle"});
  endtask
  task automatic fetch(input string tag);
    step({tag, "_t0"}, f_t0());
    run = 1'b0;
    step({tag, "_t1"}, f_t1(1'b1));
    step({tag, "_t2"}, f_t2());
  endtask
  initial begin
    clr_n = 1'b0; run = 1'b0; mem_rdy = 1'b1; ir = 32'h0;
    #2;
    exp_q.push_back(f_idle(2'b00));
    tag_q.push_back("reset");
    @(posedge clk);
    #1 clr_n = 1'b1;
    // add R1,R2,R3 with a one-cycle run pulse
    ir = 32'h1891_8000; run = 1'b1;
    fetch("add");
    step("add_t3", ex(16'h0004, 16'h0000, 5'd0, 0, 0, 1, 0, 0, 0, 0));
    step("add_t4", ex(16'h0008, 16'h0000, 5'b00011, 0, 0, 0, 1, 0, 0, 0));
    step("add_t5", ex(16'h0000, 16'h0002, 5'd0, 1, 0, 0, 0, 0, 0, 1));
    step("add_idle", f_idle(2'b00));
    // mul R4,R5 with run held, then a second mul with a slow memory
    ir = 32'h7A28_0000; run = 1'b1;
    step("mul_t0", f_t0());
    step("mul_t1", f_t1(1'b1));
    step("mul_t2", f_t2());
    step("mul_t3", ex(16'h0010, 16'h0000, 5'd0, 0, 0, 1, 0, 0, 0, 0));
    step("mul_t4", ex(16'h0020, 16'h0000, 5'b01111, 0, 0, 0, 1, 0, 0, 0));
    step("mul_t5", ex(16'h0000, 16'h0000, 5'd0, 1, 0, 0, 0, 1, 0, 0));
    step("mul_t6", ex(16'h0000, 16'h0000, 5'd0, 0, 1, 0, 0, 0, 1, 1));
    step("mul_back_t0", f_t0());
    run = 1'b0; mem_rdy = 1'b0;
    step("slow_t1_first", f_t1(1'b1));
    step("slow_t1_2", f_t1(1'b0));
    step("slow_t1_3", f_t1(1'b0));
    step("slow_t1_4", f_t1(1'b0));
    mem_rdy = 1'b1;
    step("slow_t2", f_t2());
    step("slow_t3", ex(16'h0010, 16'h0000, 5'd0, 0, 0, 1, 0, 0, 0, 0));
    step("slow_t4", ex(16'h0020, 16'h0000, 5'b01111, 0, 0, 0, 1, 0, 0, 0));
    step("slow_t5", ex(16'h0000, 16'h0000, 5'd0, 1, 0, 0, 0, 1, 0, 0));
    step("slow_t6", ex(16'h0000, 16'h0000, 5'd0, 0, 1, 0, 0, 0, 1, 1));
    step("slow_idle", f_idle(2'b00));
    // memory never ready: timeout after 15 T1 cycles, HALT ignores run
    mem_rdy = 1'b0; run = 1'b1;
    step("to_t0", f_t0());
    step("to_t1_first", f_t1(1'b1));
    for (int i = 0; i < 14; i++) step($sformatf("to_t1_%0d", i + 2), f_t1(1'b0));
    step("to_halt", f_idle(2'b10));
    step("to_halt_run1", f_idle(2'b10));
    step("to_halt_run2", f_idle(2'b10));
    reset_dut("to_clr");
    mem_rdy = 1'b1;
    // illegal opcode, then the halt opcode
    ir = 32'hF800_0000; run = 1'b1;
    fetch("ill");
    step("ill_t3", f_busy());
    step("ill_halt", f_idle(2'b01));
    step("ill_halt2", f_idle(2'b01));
    reset_dut("ill_clr");
    ir = 32'hD800_0000; run = 1'b1;
    fetch("hlt");
    step("hlt_t3", f_busy());
    step("hlt_halt", f_idle(2'b00));
    run = 1'b1;
    step("hlt_halt_run", f_idle(2'b00));
    reset_dut("hlt_clr");
    // async clear in the middle of T4
    ir = 32'h1891_8000; run = 1'b1;
    fetch("async");
    step("async_t3", ex(16'h0004, 16'h0000, 5'd0, 0, 0, 1, 0, 0, 0, 0));
    reset_dut("async_t4_clr");
    step("async_idle_hold", f_idle(2'b00));
    // neg R6,R7
    ir = 32'h8B38_0000; run = 1'b1;
    fetch("neg");
    step("neg_t3", ex(16'h0080, 16'h0000, 5'b10001, 0, 0, 0, 1, 0, 0, 0));
    step("neg_t4", ex(16'h0000, 16'h0040, 5'd0, 1, 0, 0, 0, 0, 0, 1));
    step("neg_idle", f_idle(2'b00));
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
